udp_tx_gmii_param: RTL

Parametrised GMII UDP/IPv4 frame transmitter; successor to the fixed-address, fixed-length UDP sender. Pulls payload bytes from a first-word-fall-through byte FIFO and emits complete Ethernet frames on GMII. Each frame carries preamble/SFD, MAC/IP/UDP headers built from parameters and runtime length, minimum-frame padding, and an internally computed FCS. Sits between the camera/stream FIFO and the GMII PHY pins; it needs no external CRC block.

---
 rtl/udp_tx_gmii_param_if.sv | 28 ++
 rtl/udp_tx_gmii_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_gmii_param_if.sv
// Bundle between the payload FIFO, the GMII pins and the UDP transmitter.
// The FIFO is first-word-fall-through: the head byte is always presented on fifo_dout.
interface udp_tx_gmii_param_if #(
  parameter int FIFO_CNT_W = 11
) ();
  logic                  tx_enable;
  logic [15:0]           payload_len;
  logic [7:0]            fifo_dout;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_rd_en;
  logic [7:0]            gmii_txd;
  logic                  gmii_tx_en;
  logic                  gmii_tx_er;
  logic                  busy;
  logic                  frame_done;
  logic                  len_err;
  logic [15:0]           frame_id;

  modport master (
    output tx_enable, payload_len, fifo_dout, fifo_count,
    input  fifo_rd_en, gmii_txd, gmii_tx_en, gmii_tx_er, busy, frame_done, len_err, frame_id
  );

  modport slave (
    input  tx_enable, payload_len, fifo_dout, fifo_count,
    output fifo_rd_en, gmii_txd, gmii_tx_en, gmii_tx_er, busy, frame_done, len_err, frame_id
  );
endinterface

// File: rtl/udp_tx_gmii_param.sv
// GMII UDP/IPv4 transmitter: preamble, MAC/IP/UDP header, FWFT payload, pad, CRC-32 FCS.
// The FSM state in cycle c selects the byte registered onto gmii_txd at c+1.
module udp_tx_gmii_param #(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h000A_3501_FEC0,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_0002,
  parameter logic [31:0] DST_IP      = 32'hC0A8_0003,
  parameter logic [15:0] SRC_PORT    = 16'h1F90,
  parameter logic [15:0] DST_PORT    = 16'h1F90,
  parameter logic [7:0]  TTL         = 8'h80,
  parameter int          IFG_CYCLES  = 12,
  parameter int          MAX_PAYLOAD = 1472,
  parameter int          FIFO_CNT_W  = 11
) (
  input logic                 clk,
  input logic                 rst_n,
  udp_tx_gmii_param_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_PAD, S_FCS, S_ABORT, S_IFG
  } state_t;

  localparam logic [15:0] MAXP     = 16'(MAX_PAYLOAD);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
  localparam logic [8:0]  HDR_TOP  = 9'd335;
  // Header words that do not depend on length or identification.
  localparam logic [19:0] CSUM_K   = 20'h04500 + 20'h04000 + {4'h0, TTL, 8'h11}
                                   + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
                                   + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};

  state_t      r_state, w_nxt;
  logic [15:0] r_cnt, w_cnt;
  logic [15:0] r_len, r_fid, r_csum;
  logic [19:0] r_acc;
  logic [31:0] r_crc;
  logic [7:0]  r_txd;
  logic        r_en, r_er, r_done, r_len_err;

  logic [7:0]   w_txd;
  logic         w_en, w_er, w_done, w_rd, w_crc_en, w_lerr, w_launch;
  logic [15:0]  w_iplen, w_udplen;
  logic [19:0]  w_sum;
  logic [335:0] w_hdr;
  logic [8:0]   w_hbit;
  logic [31:0]  w_crc_inv;
  logic [31:0]  w_fcnt;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
    return x;
  endfunction

  assign w_iplen   = r_len + 16'd28;
  assign w_udplen  = r_len + 16'd8;
  assign w_sum     = CSUM_K + {4'h0, w_iplen} + {4'h0, r_fid};
  assign w_hdr     = {DST_MAC, SRC_MAC, 16'h0800,
                      16'h4500, w_iplen, r_fid, 16'h4000, TTL, 8'h11, r_csum, SRC_IP, DST_IP,
                      SRC_PORT, DST_PORT, w_udplen, 16'h0000};
  assign w_hbit    = HDR_TOP - {r_cnt[5:0], 3'b000};
  assign w_crc_inv = ~r_crc;
  assign w_fcnt    = 32'(bus.fifo_count);

  always_comb begin
    w_nxt    = r_state;
    w_cnt    = r_cnt;
    w_txd    = 8'h00;
    w_en     = 1'b0;
    w_er     = 1'b0;
    w_done   = 1'b0;
    w_rd     = 1'b0;
    w_crc_en = 1'b0;
    w_lerr   = 1'b0;
    w_launch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.tx_enable) begin
          if (bus.payload_len == 16'd0 || bus.payload_len > MAXP) begin
            w_lerr = 1'b1;
          end else if (w_fcnt >= 32'(bus.payload_len)) begin
            // The launch cycle already emits preamble byte 0.
            w_launch = 1'b1;
            w_en     = 1'b1;
            w_txd    = 8'h55;
            w_nxt    = S_PREAMBLE;
            w_cnt    = 16'd1;
          end
        end
      end
      S_PREAMBLE: begin
        w_en = 1'b1;
        if (r_cnt == 16'd7) begin
          w_txd = 8'hD5;
          w_nxt = S_HEADER;
          w_cnt = 16'd0;
        end else begin
          w_txd = 8'h55;
          w_cnt = r_cnt + 16'd1;
        end
      end
      S_HEADER: begin
        w_en     = 1'b1;
        w_txd    = w_hdr[w_hbit -: 8];
        w_crc_en = 1'b1;
        if (r_cnt == 16'd41) begin
          w_nxt = S_PAYLOAD;
          w_cnt = 16'd0;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      S_PAYLOAD: begin
        w_en = 1'b1;
        if (bus.fifo_count == '0) begin
          w_er  = 1'b1;
          w_nxt = S_ABORT;
        end else begin
          w_rd     = 1'b1;
          w_txd    = bus.fifo_dout;
          w_crc_en = 1'b1;
          if (r_cnt == r_len - 16'd1) begin
            w_cnt = 16'd0;
            w_nxt = (r_len < 16'd18) ? S_PAD : S_FCS;
          end else begin
            w_cnt = r_cnt + 16'd1;
          end
        end
      end
      S_PAD: begin
        w_en     = 1'b1;
        w_crc_en = 1'b1;
        if (r_cnt == 16'd17 - r_len) begin
          w_cnt = 16'd0;
          w_nxt = S_FCS;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      S_FCS: begin
        w_en  = 1'b1;
        w_txd = w_crc_inv[{r_cnt[1:0], 3'b000} +: 8];
        if (r_cnt == 16'd3) begin
          w_cnt = 16'd0;
          w_nxt = S_IFG;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      S_ABORT: begin
        // This cycle already counts as the first idle cycle of the gap.
        w_done = 1'b1;
        w_cnt  = 16'd1;
        w_nxt  = S_IFG;
      end
      S_IFG: begin
        w_done = (r_cnt == 16'd0);
        if (r_cnt == IFG_LAST) begin
          w_cnt = 16'd0;
          w_nxt = S_IDLE;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_nxt = S_IDLE;
        w_cnt = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_len     <= 16'd0;
      r_fid     <= 16'd0;
      r_acc     <= 20'd0;
      r_csum    <= 16'd0;
      r_crc     <= 32'hFFFF_FFFF;
      r_txd     <= 8'h00;
      r_en      <= 1'b0;
      r_er      <= 1'b0;
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= w_cnt;
      r_txd     <= w_txd;
      r_en      <= w_en;
      r_er      <= w_er;
      r_done    <= w_done;
      r_len_err <= w_lerr;
      if (w_launch) begin
        r_len <= bus.payload_len;
        r_fid <= r_fid + 16'd1;
        r_crc <= 32'hFFFF_FFFF;
      end else if (w_crc_en) begin
        r_crc <= crc_byte(r_crc, w_txd);
      end
      // Header checksum: sum, fold, fold+invert while the preamble is on the wire.
      if (r_state == S_PREAMBLE) begin
        if (r_cnt == 16'd1) r_acc  <= w_sum;
        if (r_cnt == 16'd2) r_acc  <= {4'h0, r_acc[15:0]} + {16'h0, r_acc[19:16]};
        if (r_cnt == 16'd3) r_csum <= ~(r_acc[15:0] + {12'h0, r_acc[19:16]});
      end
    end
  end

  assign bus.fifo_rd_en = w_rd;
  assign bus.gmii_txd   = r_txd;
  assign bus.gmii_tx_en = r_en;
  assign bus.gmii_tx_er = r_er;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_done = r_done;
  assign bus.len_err    = r_len_err;
  assign bus.frame_id   = r_fid;

endmodule
